// File: rtl/fa_pkg.sv
// fa_pkg: shared definitions for the fa_accum_fifo arithmetic stage.
//   fa_mode_t - 2-bit operation select carried on in_mode.
//   MODE_*    - encodings for ADD, DBL, ACC and CLR.
package fa_pkg;

  typedef logic [1:0] fa_mode_t;

  localparam fa_mode_t MODE_ADD = 2'b00;
  localparam fa_mode_t MODE_DBL = 2'b01;
  localparam fa_mode_t MODE_ACC = 2'b10;
  localparam fa_mode_t MODE_CLR = 2'b11;

endpackage

// File: rtl/fa_accum_fifo_if.sv
// fa_accum_fifo_if: operand and result handshakes of the arithmetic stage.
//   in_valid/in_ready/in_mode/in_a/in_b  - operand channel (producer -> block)
//   out_valid/out_ready/out_data/out_carry - result channel (block -> consumer)
//   level, ovf_sticky                      - status from the block
//   modport master: the producer/consumer side; modport slave: the block.
//
// Handshake rule for both channels: a transfer happens on a rising clk edge
// exactly when valid and ready are both high. Once valid is raised the
// sender holds valid and its payload stable until that transfer occurs.
interface fa_accum_fifo_if
  import fa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  fa_mode_t         in_mode;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic [LW-1:0]    level;
  logic             ovf_sticky;

  modport master (
    output in_valid, in_mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_carry, level, ovf_sticky
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_carry, level, ovf_sticky
  );

endinterface

// File: rtl/fa_sync_fifo.sv
// fa_sync_fifo: generic single-clock FIFO with occupancy count.
//   clk, rst_n      - clock, asynchronous active-low reset
//   push_i, wdata_i - write request and data
//   pop_i           - remove head entry
//   rdata_o         - head entry, zero while empty
//   full_o, empty_o - occupancy flags
//   level_o         - number of stored entries, 0..DEPTH
// A push while full is only honoured together with a pop (push-through).
module fa_sync_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   level_q, level_d;
  logic          push_en, pop_en;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == DEPTH_L);
  assign pop_en  = pop_i & ~empty_o;
  assign push_en = push_i & (~full_o | pop_en);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: stale words are never visible through rdata_o.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fa_accum_fifo.sv
// fa_accum_fifo: arithmetic stage with accumulator and buffered results.
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - fa_accum_fifo_if.slave: operand channel (mode/a/b), result
//                channel (data/carry), FIFO level and sticky overflow flag.
// Each accepted operand pair produces exactly one result entry; results are
// written into the FIFO on the accept edge, so no input reaches the output
// in the same cycle.
module fa_accum_fifo
  import fa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SAT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  fa_accum_fifo_if.slave bus
);
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic [WIDTH-1:0] res;
  logic             accept, pop;
  logic             fifo_full, fifo_empty;
  logic [WIDTH:0]   head;

  // Operand routing: CLR feeds zeros so its sum and carry are both zero.
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (bus.in_mode)
      MODE_ADD: begin op_a = bus.in_a; op_b = bus.in_b; end
      MODE_DBL: begin op_a = bus.in_a; op_b = bus.in_a; end
      MODE_ACC: begin op_a = acc_q;    op_b = bus.in_a; end
      MODE_CLR: begin op_a = '0;       op_b = '0;       end
    endcase
    sum   = {1'b0, op_a} + {1'b0, op_b};
    carry = sum[WIDTH];
    res   = (SAT != 0 && carry) ? '1 : sum[WIDTH-1:0];
  end

  // Full FIFO still accepts when the consumer drains the head this cycle.
  assign bus.in_ready = ~fifo_full | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign pop          = ~fifo_empty & bus.out_ready;

  always_comb begin
    acc_d    = acc_q;
    sticky_d = sticky_q;
    if (accept) begin
      if (carry) sticky_d = 1'b1;
      case (bus.in_mode)
        MODE_ACC: acc_d = res;
        MODE_CLR: begin
          acc_d    = '0;
          sticky_d = 1'b0;
        end
        default: acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      sticky_q <= sticky_d;
    end
  end

  fa_sync_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i ({carry, res}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (bus.level)
  );

  assign bus.out_valid  = ~fifo_empty;
  assign bus.out_data   = head[WIDTH-1:0];
  assign bus.out_carry  = head[WIDTH];
  assign bus.ovf_sticky = sticky_q;

endmodule
